// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer control stage.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int          NUM_DIGITS    = 4;
    localparam logic [3:0]  BCD_MAX       = 4'd9;
    localparam logic [1:0]  LOAD_GUARD    = 2'd2;

    localparam logic [1:0]  CUR_ONES      = 2'd0;
    localparam logic [1:0]  CUR_TENS      = 2'd1;
    localparam logic [1:0]  CUR_HUNDREDS  = 2'd2;
    localparam logic [1:0]  CUR_THOUSANDS = 2'd3;

    // Wraps 9 -> 0 and also folds any illegal code back to 0.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/countdown_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle press pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int            CW   = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          armed_q;
    logic          press_q;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d   = '0;
            level_d = sync_q[1];
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchronizer resets high and presses stay disarmed until a released
    // sample is seen, so a button held through reset never yields a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            armed_q     <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], raw};
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            if (!sync_q[1]) begin
                armed_q <= 1'b1;
            end
            press_q     <= level_q & ~level_dly_q & armed_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/countdown_ctrl.sv
// Control stage for the 4-digit BCD countdown: preset editing, start/pause/
// clear FSM, tick prescaler and expiry alarm.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_sel,
    input  logic       btn_up,
    input  logic       btn_start,
    input  logic       btn_clr,
    input  logic       cnt_zero,
    output logic [3:0] is1000,
    output logic [3:0] is100,
    output logic [3:0] is10,
    output logic [3:0] is1,
    output logic       key,
    output logic       decrease,
    output logic [1:0] cursor,
    output logic [1:0] state,
    output logic       alarm
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    localparam int BTN_UP    = 0;
    localparam int BTN_SEL   = 1;
    localparam int BTN_START = 2;
    localparam int BTN_CLR   = 3;

    logic [3:0] btn_raw;
    logic [3:0] btn_press;
    logic [3:0] btn_level_unused;

    assign btn_raw = {btn_clr, btn_start, btn_sel, btn_up};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk   (clk),
                .rst_n (rst_n),
                .raw   (btn_raw[gi]),
                .level (btn_level_unused[gi]),
                .press (btn_press[gi])
            );
        end
    endgenerate

    state_e        state_q, state_d;
    logic [3:0]    digit_q [NUM_DIGITS];
    logic [3:0]    digit_d [NUM_DIGITS];
    logic [1:0]    cursor_q, cursor_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    guard_q, guard_d;
    logic          key_q, key_d;
    logic          preset_nonzero;

    assign preset_nonzero = (digit_q[0] != 4'd0) || (digit_q[1] != 4'd0) ||
                            (digit_q[2] != 4'd0) || (digit_q[3] != 4'd0);

    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        cursor_d = cursor_q;
        presc_d  = presc_q;
        guard_d  = guard_q;
        key_d    = 1'b0;
        case (state_q)
            ST_SET: begin
                if (btn_press[BTN_CLR]) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        digit_d[i] = 4'd0;
                    end
                    cursor_d = CUR_ONES;
                end else if (btn_press[BTN_START]) begin
                    if (preset_nonzero) begin
                        state_d = ST_RUN;
                        key_d   = 1'b1;
                        presc_d = '0;
                        guard_d = LOAD_GUARD;
                    end
                end else if (btn_press[BTN_SEL]) begin
                    cursor_d = cursor_q + 2'd1;
                end else if (btn_press[BTN_UP]) begin
                    digit_d[cursor_q] = bcd_inc(digit_q[cursor_q]);
                end
            end
            ST_RUN: begin
                if (btn_press[BTN_CLR]) begin
                    state_d = ST_SET;
                end else if (btn_press[BTN_START]) begin
                    state_d = ST_PAUSE;
                end else if ((guard_q == 2'd0) && cnt_zero) begin
                    state_d = ST_DONE;
                end
                if (guard_q != 2'd0) begin
                    guard_d = guard_q - 2'd1;
                end
                // Hold during the load cycle so the first tick lands TICK_DIV
                // cycles after key; freeze when leaving so a pause keeps phase.
                if ((state_d == ST_RUN) && !key_q) begin
                    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
                end
            end
            ST_PAUSE: begin
                if (btn_press[BTN_CLR]) begin
                    state_d = ST_SET;
                end else if (btn_press[BTN_START]) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (btn_press[BTN_CLR] || btn_press[BTN_START]) begin
                    state_d = ST_SET;
                end
            end
            default: state_d = ST_SET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SET;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= 4'd0;
            end
            cursor_q <= CUR_ONES;
            presc_q  <= '0;
            guard_q  <= 2'd0;
            key_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            digit_q  <= digit_d;
            cursor_q <= cursor_d;
            presc_q  <= presc_d;
            guard_q  <= guard_d;
            key_q    <= key_d;
        end
    end

    assign is1      = digit_q[CUR_ONES];
    assign is10     = digit_q[CUR_TENS];
    assign is100    = digit_q[CUR_HUNDREDS];
    assign is1000   = digit_q[CUR_THOUSANDS];
    assign key      = key_q;
    assign decrease = (state_q == ST_RUN) && (state_d == ST_RUN) && (presc_q == PRESC_LAST);
    assign cursor   = cursor_q;
    assign state    = state_q;
    assign alarm    = (state_q == ST_DONE);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with TICK_DIV=10, DEB_CYCLES=4.
module tb_countdown_ctrl;

    localparam logic [1:0] S_SET   = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic       clk;
    logic       rst_n;
    logic       btn_sel, btn_up, btn_start, btn_clr;
    logic       cnt_zero;
    logic [3:0] is1000, is100, is10, is1;
    logic       key, decrease, alarm;
    logic [1:0] cursor, state;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int key_cnt  = 0;

    countdown_ctrl #(.TICK_DIV(10), .DEB_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_sel   (btn_sel),
        .btn_up    (btn_up),
        .btn_start (btn_start),
        .btn_clr   (btn_clr),
        .cnt_zero  (cnt_zero),
        .is1000    (is1000),
        .is100     (is100),
        .is10      (is10),
        .is1       (is1),
        .key       (key),
        .decrease  (decrease),
        .cursor    (cursor),
        .state     (state),
        .alarm     (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && key) key_cnt <= key_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_up    = v;
            1: btn_sel   = v;
            2: btn_start = v;
            default: btn_clr = v;
        endcase
    endtask

    task automatic press(input int b);
        $display("press btn=%0d at cycle %0d", b, cyc);
        set_btn(b, 1'b1);
        repeat (12) @(negedge clk);
        set_btn(b, 1'b0);
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_key(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (key === 1'b1) begin at = cyc; break; end
        end
    endtask

    task automatic wait_dec(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (decrease === 1'b1) begin at = cyc; break; end
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (state === s) begin at = cyc; break; end
        end
    endtask

    initial begin
        int k, d1, d2, tp, r, held, cnt, kc;
        rst_n = 1'b1;
        btn_sel = 0; btn_up = 0; btn_start = 0; btn_clr = 0; cnt_zero = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // 1. reset values, then digit editing and clear
        chk("rst_state", state, S_SET);
        chk("rst_is1", is1, 0);
        chk("rst_cursor", cursor, 0);
        chk("rst_key", key, 0);
        chk("rst_decrease", decrease, 0);
        chk("rst_alarm", alarm, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        repeat (3) press(0);
        press(1);
        repeat (2) press(0);
        chk("edit_is1", is1, 3);
        chk("edit_is10", is10, 2);
        chk("edit_cursor", cursor, 1);
        press(3);
        chk("clr_is1", is1, 0);
        chk("clr_is10", is10, 0);
        chk("clr_cursor", cursor, 0);

        // 2. ones digit wraps 9 -> 0
        for (int i = 1; i <= 10; i++) begin
            press(0);
            chk($sformatf("up_seq%0d", i), is1, i % 10);
        end
        chk("up_others", {is1000, is100, is10}, 0);

        // 3. preset 0002, run, two ticks, expiry
        repeat (2) press(0);
        chk("preset_is1", is1, 2);
        btn_start = 1'b1;
        wait_key(30, k);
        btn_start = 1'b0;
        chk("run_key_seen", 32'(k >= 0), 1);
        chk("run_key_state", state, S_RUN);
        @(negedge clk);
        chk("run_key_width", key, 0);
        wait_dec(30, d1);
        chk("run_first_tick", d1 - k, 10);
        wait_dec(30, d2);
        chk("run_tick_period", d2 - d1, 10);
        @(negedge clk);
        cnt_zero = 1'b1;
        @(negedge clk);
        chk("done_state", state, S_DONE);
        chk("done_alarm", alarm, 1);
        cnt = 0;
        repeat (30) begin @(negedge clk); if (decrease) cnt++; end
        chk("done_no_ticks", cnt, 0);
        cnt_zero = 1'b0;
        press(3);
        chk("done_clr_state", state, S_SET);
        chk("done_clr_alarm", alarm, 0);
        chk("done_keeps_is1", is1, 2);

        // 4. zero preset start ignored; load guard
        press(3);
        kc = key_cnt;
        press(2);
        chk("zero_start_state", state, S_SET);
        chk("zero_start_nokey", key_cnt, kc);
        press(0);
        chk("guard_is1", is1, 1);
        cnt_zero = 1'b1;
        btn_start = 1'b1;
        wait_key(30, k);
        btn_start = 1'b0;
        chk("guard_key_seen", 32'(k >= 0), 1);
        @(negedge clk);
        chk("guard_cycle1", state, S_RUN);
        @(negedge clk);
        chk("guard_cycle2", state, S_RUN);
        @(negedge clk);
        chk("guard_done", state, S_DONE);
        cnt_zero = 1'b0;
        press(3);
        chk("guard_clr", state, S_SET);

        // 5. pause at prescaler 6, resume without reload
        btn_start = 1'b1;
        wait_key(30, k);
        btn_start = 1'b0;
        wait_dec(30, d1);
        chk("pause_first_tick", d1 - k, 10);
        btn_start = 1'b1;
        wait_state(S_PAUSE, 30, tp);
        btn_start = 1'b0;
        chk("pause_latency", tp - d1, 8);
        held = tp - d1 - 2;
        kc = key_cnt;
        cnt = 0;
        repeat (50) begin @(negedge clk); if (decrease) cnt++; end
        chk("pause_no_ticks", cnt, 0);
        chk("pause_state", state, S_PAUSE);
        btn_start = 1'b1;
        wait_state(S_RUN, 30, r);
        btn_start = 1'b0;
        chk("resume_seen", 32'(r >= 0), 1);
        chk("resume_no_key", key, 0);
        wait_dec(30, d2);
        chk("resume_tick", d2 - r, 9 - held);
        chk("resume_keycnt", key_cnt, kc);

        // 6. clr+start together in RUN, bounce, async reset
        btn_clr = 1'b1; btn_start = 1'b1;
        repeat (10) @(negedge clk);
        chk("prio_state", state, S_SET);
        btn_clr = 1'b0; btn_start = 1'b0;
        repeat (12) @(negedge clk);
        chk("prio_keeps_is1", is1, 1);
        repeat (8) begin
            btn_up = 1'b1; repeat (2) @(negedge clk);
            btn_up = 1'b0; repeat (2) @(negedge clk);
        end
        repeat (15) @(negedge clk);
        chk("bounce_is1", is1, 1);
        btn_start = 1'b1;
        wait_key(30, k);
        btn_start = 1'b0;
        repeat (5) @(negedge clk);
        chk("prereset_state", state, S_RUN);
        btn_up = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_state", state, S_SET);
        chk("async_is1", is1, 0);
        chk("async_cursor", cursor, 0);
        chk("async_key", key, 0);
        chk("async_decrease", decrease, 0);
        chk("async_alarm", alarm, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("held_through_rst", is1, 0);
        btn_up = 1'b0;
        repeat (20) @(negedge clk);
        press(0);
        chk("post_rst_up", is1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
